// File: rtl/xbar_ingress_requester_if.sv
// Bundle of all signals between the xbar ingress requester and its neighbours:
// the descriptor source, the payload source, the arbiter row and the crossbar.
interface xbar_ingress_requester_if #(
    parameter int DW = 8
);
    logic          desc_valid;
    logic [1:0]    desc_addr;
    logic [3:0]    desc_len;
    logic          desc_ready;
    logic          din_valid;
    logic [DW-1:0] din_data;
    logic          din_ready;
    logic          req;
    logic [1:0]    addr;
    logic          grant;
    logic          out_blocked;
    logic          x_valid;
    logic [DW-1:0] x_data;
    logic          x_last;
    logic          starve;

    // The requester itself.
    modport master (
        input  desc_valid, desc_addr, desc_len, din_valid, din_data, grant, out_blocked,
        output desc_ready, din_ready, req, addr, x_valid, x_data, x_last, starve
    );

    // The surrounding environment (sources, arbiter, crossbar).
    modport slave (
        output desc_valid, desc_addr, desc_len, din_valid, din_data, grant, out_blocked,
        input  desc_ready, din_ready, req, addr, x_valid, x_data, x_last, starve
    );
endinterface

// File: rtl/xbar_ingress_requester.sv
// Crossbar ingress requester: queues packet descriptors, requests an output port
// from the wavefront arbiter and streams the payload beats while the crosspoint is held.
module xbar_ingress_requester #(
    parameter int          DW           = 8,
    parameter int          DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    xbar_ingress_requester_if.master bus
);
    // DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } state_e;

    typedef struct packed {
        logic [1:0] addr;
        logic [3:0] len;
    } desc_t;

    state_e        state;
    state_e        state_nxt;
    desc_t         fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    addr_reg;
    logic [3:0]    len_reg;
    logic [3:0]    beat_cnt;
    logic [3:0]    wait_cnt;
    logic [DW-1:0] x_data_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          beat;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.desc_valid & ~full;
    assign pop   = (state == IDLE) & ~empty;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so that no path through the case infers a latch.
        state_nxt = state;
        bus.req   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_nxt = REQ;
            end
            REQ: begin
                bus.req = 1'b1;
                if (bus.grant && !bus.out_blocked) state_nxt = XFER;
            end
            XFER: begin
                bus.req = 1'b1;
                if (beat && (beat_cnt == len_reg)) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A beat moves only while the crosspoint is granted and the port is free;
    // the reset cycle itself never emits a beat.
    assign beat           = (state == XFER) & bus.din_valid & ~bus.out_blocked & bus.grant & ~reset;
    assign bus.din_ready  = beat;
    assign bus.x_valid    = beat;
    assign bus.x_last     = beat & (beat_cnt == len_reg);
    assign bus.x_data     = (state == XFER) ? bus.din_data : x_data_q;
    assign bus.addr       = bus.req ? addr_reg : 2'd0;
    assign bus.desc_ready = ~full;
    assign bus.starve     = ({28'd0, wait_cnt} >= STARVE_LIMIT);

    // NOTE: descriptor storage is not reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= desc_t'{addr: bus.desc_addr, len: bus.desc_len};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg <= '0;
            len_reg  <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            x_data_q <= '0;
        end else begin
            if (pop) begin
                addr_reg <= fifo_mem[rd_ptr].addr;
                len_reg  <= fifo_mem[rd_ptr].len;
            end
            if (state == REQ)  beat_cnt <= '0;
            else if (beat)     beat_cnt <= beat_cnt + 1'b1;
            // Grant with a blocked port keeps us in REQ without counting a wait.
            if (state == REQ && state_nxt != REQ) begin
                wait_cnt <= '0;
            end else if (state == REQ && !bus.grant && wait_cnt != 4'hF) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == XFER) x_data_q <= bus.din_data;
        end
    end
endmodule

// File: tb/tb_xbar_ingress_requester.sv
// Scoreboard bench for xbar_ingress_requester: accepted descriptors queue their
// expected beats; an independent monitor checks every presented beat and the starve flag.
module tb_xbar_ingress_requester;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 15;

    typedef struct {
        logic [1:0]    addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xbar_ingress_requester_if #(.DW(DW)) bus ();

    xbar_ingress_requester #(
        .DW(DW),
        .DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    beat_t         exp_q[$];
    logic [DW-1:0] src_q[$];
    int            tests = 0;
    int            fails = 0;
    logic          s_req, s_xv, s_xlast, s_starve, s_dr, s_dinr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; an accepted descriptor queues its payload and expected beats.
    task automatic step(input logic dv, input logic [1:0] da, input logic [3:0] dl,
                        input logic dinv, input logic g, input logic ob);
        @(negedge clk);
        bus.desc_valid  = dv;
        bus.desc_addr   = da;
        bus.desc_len    = dl;
        bus.din_valid   = dinv && (src_q.size() > 0);
        bus.din_data    = (src_q.size() > 0) ? src_q[0] : '0;
        bus.grant       = g;
        bus.out_blocked = ob;
        #1;
        s_req = bus.req; s_xv = bus.x_valid; s_xlast = bus.x_last;
        s_starve = bus.starve; s_dr = bus.desc_ready; s_dinr = bus.din_ready;
        if (dv && bus.desc_ready && !reset) begin
            for (int i = 0; i <= int'(dl); i++) begin
                logic [DW-1:0] d;
                d = DW'($urandom);
                src_q.push_back(d);
                exp_q.push_back('{addr: da, data: d, last: (i == int'(dl))});
            end
        end
        if (bus.din_ready) void'(src_q.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        check("drain_complete", exp_q.size(), 0);
        idle(3);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},        bus.req, 0);
        check({tag, "_addr"},       bus.addr, 0);
        check({tag, "_x_valid"},    bus.x_valid, 0);
        check({tag, "_x_last"},     bus.x_last, 0);
        check({tag, "_din_ready"},  bus.din_ready, 0);
        check({tag, "_desc_ready"}, bus.desc_ready, 1);
        check({tag, "_starve"},     bus.starve, 0);
        check({tag, "_x_data"},     bus.x_data, 0);
    endtask

    // Monitor: wait cycles are counted from the observable request, independent of stimulus.
    int waitc   = 0;
    bit granted = 1'b0;
    bit prev_last = 1'b0;
    always @(negedge clk) begin
        #2;
        if (reset) begin
            waitc = 0; granted = 1'b0; prev_last = 1'b0;
        end else begin
            check("starve", bus.starve, (waitc >= LIMIT));
            if (prev_last) check("req_release", bus.req, 0);
            if (bus.req && !granted && exp_q.size() > 0) check("req_addr", bus.addr, exp_q[0].addr);
            if (bus.x_valid) begin
                check("beat_handshake", {bus.din_ready, bus.din_valid, bus.grant, bus.out_blocked, bus.req}, 5'b11101);
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", bus.x_data, e.data);
                    check("beat_last", bus.x_last, e.last);
                    check("beat_addr", bus.addr, e.addr);
                end
            end else begin
                check("no_beat_outputs", {bus.x_last, bus.din_ready}, 0);
            end
            if (!bus.req) begin
                granted = 1'b0;
            end else if (!granted) begin
                if (bus.grant && !bus.out_blocked) begin
                    granted = 1'b1;
                    waitc   = 0;
                end else if (!bus.grant && waitc < 15) begin
                    waitc++;
                end
            end
            prev_last = bus.x_valid && bus.x_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] req_seq, xv_seq, last_seq;
        int first, nbeats, nlast;
        logic [4:0] dr_seq;

        bus.desc_valid = 0; bus.desc_addr = 0; bus.desc_len = 0;
        bus.din_valid = 0; bus.din_data = 0; bus.grant = 0; bus.out_blocked = 0;
        @(negedge clk); @(negedge clk); #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single 4-beat packet granted on the first request cycle.
        step(1'b1, 2'd2, 4'd3, 1'b1, 1'b1, 1'b0);
        check("push_cycle_req", s_req, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
            req_seq[7-i] = s_req; xv_seq[7-i] = s_xv; last_seq[7-i] = s_xlast;
        end
        check("pkt4_req_seq",  req_seq,  8'b0111_1100);
        check("pkt4_xv_seq",   xv_seq,   8'b0011_1100);
        check("pkt4_last_seq", last_seq, 8'b0000_0100);

        // FIFO fill while the head waits ungranted, then starve behaviour.
        step(1'b1, 2'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        first = -1;
        for (int k = 0; k < 20; k++) begin
            step(k < 5, 2'($urandom), 4'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
            if (k < 5) dr_seq[4-k] = s_dr;
            if (s_starve && first < 0) first = k;
        end
        check("fifo_full_ready_seq", dr_seq, 5'b11110);
        check("starve_rise_cycle", first, LIMIT);
        step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        check("starve_held_in_grant_cycle", s_starve, 1);
        step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        check("starve_cleared_after_grant", s_starve, 0);
        drain(200);

        // Backpressure on the second beat of a 3-beat packet.
        step(1'b1, 2'd1, 4'd2, 1'b1, 1'b1, 1'b0);
        nbeats = 0;
        for (int i = 0; i < 10 && nbeats == 0; i++) begin
            step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
            if (s_xv) nbeats++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1);
            check("blocked_no_beat", {s_xv, s_dinr}, 2'b00);
        end
        for (int i = 0; i < 10 && !(s_xv && s_xlast); i++) begin
            step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
            if (s_xv) nbeats++;
        end
        check("blocked_pkt_beats", nbeats, 3);
        idle(3);

        // Reset in the middle of a long packet with two descriptors queued.
        step(1'b1, 2'd3, 4'd7, 1'b1, 1'b1, 1'b0);
        step(1'b1, 2'd1, 4'd2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 2'd2, 4'd1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10 && !s_xv; i++) step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        check("mid_pkt_first_beat_seen", s_xv, 1);
        @(negedge clk);
        reset = 1'b1;
        bus.desc_valid = 1'b0;
        #1;
        check("no_beat_in_reset_cycle", {bus.x_valid, bus.din_ready, bus.x_last}, 3'b000);
        exp_q.delete();
        src_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
            check("fifo_empty_after_reset", s_req, 0);
        end

        // Zero-length descriptor.
        step(1'b1, 2'd3, 4'd0, 1'b1, 1'b1, 1'b0);
        nbeats = 0; nlast = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b0);
            if (s_xv) nbeats++;
            if (s_xv && s_xlast) nlast++;
        end
        check("len0_beats", nbeats, 1);
        check("len0_last", nlast, 1);

        // Randomised traffic with grant loss, backpressure and FIFO overflow attempts.
        for (int i = 0; i < 2500; i++) begin
            step(($urandom % 3) == 0, 2'($urandom), 4'($urandom), ($urandom % 10) < 8,
                 ($urandom % 10) < 7, ($urandom % 10) < 2);
        end
        drain(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/xbar_ingress_requester.md
XBAR_INGRESS_REQUESTER -- requirements
Module: xbar_ingress_requester

Interface
REQ-001 Parameter DW, default 8, xbar data word width in bits.
REQ-002 Parameter DEPTH, default 4, descriptor FIFO entries; SHALL be a power of two.
REQ-003 Parameter STARVE_LIMIT, default 15, wait cycles before the starve flag is raised.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 desc_valid  input  1  upstream offers a descriptor.
REQ-007 desc_addr  input  2  destination output port 0..3.
REQ-008 desc_len  input  4  packet length in beats minus 1 (0 = 1 beat, 15 = 16 beats).
REQ-009 desc_ready  output  1  descriptor FIFO not full.
REQ-010 din_valid  input  1  upstream payload beat available.
REQ-011 din_data  input  DW  payload beat.
REQ-012 din_ready  output  1  payload beat consumed this cycle.
REQ-013 req  output  1  request to the wavefront arbiter row.
REQ-014 addr  output  2  requested output port.
REQ-015 grant  input  1  OR of the arbiter row results; valid in the same cycle as req.
REQ-016 out_blocked  input  1  destination port backpressure.
REQ-017 x_valid  output  1  beat presented to the crossbar.
REQ-018 x_data  output  DW  beat data.
REQ-019 x_last  output  1  final beat of the packet.
REQ-020 starve  output  1  request pending for at least STARVE_LIMIT cycles.

Function
REQ-021 Descriptor FIFO: push when desc_valid and desc_ready; pop when the head descriptor is loaded in IDLE; simultaneous push and pop on a full FIFO SHALL be rejected (desc_ready=0 when full); pointers SHALL wrap modulo DEPTH.
REQ-022 FSM states: IDLE, REQ, XFER, DONE.
REQ-023 IDLE: when the FIFO is non-empty, load addr_reg/len_reg from the head, pop it, and go to REQ next cycle; otherwise stay in IDLE.
REQ-024 REQ: req=1 and addr=addr_reg; grant=1 and out_blocked=0 -> XFER next cycle with beat counter=0; otherwise stay in REQ.
REQ-025 XFER: req SHALL remain 1 to hold the crosspoint; din_ready = din_valid & ~out_blocked; x_valid = din_ready; x_data = din_data combinationally.
REQ-026 Beat counter SHALL increment on each transferred beat; x_last=1 when counter==len_reg and x_valid=1; that beat -> DONE.
REQ-027 Loss of grant in XFER (grant=0) SHALL stall transfer (din_ready=0) without losing the counter; return of grant resumes.
REQ-028 DONE: req=0 for exactly one cycle to release the crosspoint, then IDLE.
REQ-029 Wait counter: 4-bit, clears when leaving REQ, increments each REQ cycle without grant, saturates at 15; starve=1 when counter>=STARVE_LIMIT.
REQ-030 Outside REQ/XFER: req=0, x_valid=0, x_last=0, din_ready=0; x_data holds its last value.
REQ-031 A descriptor with desc_len=0 SHALL produce one beat with x_last=1.

Reset
REQ-032 reset=1 SHALL within one clock set FSM=IDLE, FIFO empty, counters=0, req=0, addr=0, x_valid=0, x_last=0, din_ready=0, desc_ready=1, starve=0, x_data=0.
REQ-033 reset mid-XFER SHALL abort the packet and drop the remaining FIFO contents; no beat is emitted in the reset cycle.

Verification
REQ-034 Push {addr=2,len=3}, grant=1 on the first req cycle, din always valid -> req high 1 cycle, then 4 x_valid beats, x_last on 4th, req low one cycle.
REQ-035 Push 5 descriptors back-to-back with no pop -> desc_ready drops after the 4th; 5th is not accepted.
REQ-036 Hold grant=0 for 20 cycles in REQ -> starve rises at the 15th wait cycle, clears the cycle after grant.
REQ-037 out_blocked=1 on beat 2 of a len=2 packet for 3 cycles -> din_ready/x_valid low 3 cycles, then beats resume; total 3 beats.
REQ-038 reset asserted on beat 1 of len=7 with 2 queued descriptors -> next cycle all outputs at reset values, FIFO empty.
REQ-039 len=0 descriptor -> single beat with x_valid=1 and x_last=1.
